// File: rtl/game_sched.sv
// game_sched -- two-player counter ownership scheduler.
//
// Arbitrates which of two players owns a shared up/down counter. A round
// runs IDLE -> GRANT -> RUN -> RELEASE -> IDLE. The owner is picked round-robin.
// During RUN the owner's step code is forwarded to the counter with one cycle
// of latency. GAMEOVER aborts to CLEAR, which pulses game_reset for one cycle.
// All outputs are registered.
//
// Optional feature: define SCHED_TIMEOUT_EN to end a RUN phase after ROUND_MAX
// consecutive RUN cycles with no WINNER/LOSER. A timed-out round still counts
// as a completed round.
//
// Ports:
//   clk                 single clock, all state updates on posedge
//   reset_n             asynchronous active-low reset
//   req[1:0]            ownership requests, bit0 = player 0, bit1 = player 1
//   p0_ctrl, p1_ctrl    step codes (00 +1, 01 +2, 10 -1, 11 -2)
//   p0_load, p1_load    preload the counter when granted
//   p0_init, p1_init    preload values
//   WINNER, LOSER       round-ending status from the datapath
//   GAMEOVER            game-ending status from the datapath
//   gnt[1:0]            one-hot grant, 00 when nobody owns the counter
//   control[1:0]        step code driven to the counter
//   INIT_c, INIT_l      counter load strobe / load value
//   game_reset          one-cycle synchronous reset pulse to the datapath
//   rounds[7:0]         completed-round count, wraps 255 -> 0
module game_sched #(
  parameter int SIZE      = 4,
  parameter int ROUND_MAX = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      req,
  input  logic [1:0]      p0_ctrl,
  input  logic [1:0]      p1_ctrl,
  input  logic            p0_load,
  input  logic            p1_load,
  input  logic [SIZE-1:0] p0_init,
  input  logic [SIZE-1:0] p1_init,
  input  logic            WINNER,
  input  logic            LOSER,
  input  logic            GAMEOVER,
  output logic [1:0]      gnt,
  output logic [1:0]      control,
  output logic            INIT_c,
  output logic [SIZE-1:0] INIT_l,
  output logic            game_reset,
  output logic [7:0]      rounds
);

  typedef enum logic [2:0] {IDLE, GRANT, RUN, RELEASE, CLEAR} state_t;

  state_t state;
  logic   owner;       // player currently holding the grant
  logic   last_owner;  // round-robin pointer; 1 means player 0 wins a tie

  // Requester picked this cycle: a lone requester wins, a tie goes to the
  // player that did not own the previous round.
  logic            pick;
  logic            pick_load;
  logic [SIZE-1:0] pick_init;
  logic [1:0]      owner_ctrl;
  logic            run_expired;

  assign pick       = req[1] & (~req[0] | ~last_owner);
  assign pick_load  = pick ? p1_load : p0_load;
  assign pick_init  = pick ? p1_init : p0_init;
  assign owner_ctrl = owner ? p1_ctrl : p0_ctrl;

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(ROUND_MAX + 1);
  logic [CNT_W-1:0] run_cnt;
  // run_cnt counts RUN cycles already completed; the ROUND_MAX-th RUN cycle
  // is the last one.
  assign run_expired = (run_cnt == CNT_W'(ROUND_MAX - 1));
`else
  assign run_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt        <= 2'b00;
      control    <= 2'b00;
      INIT_c     <= 1'b0;
      INIT_l     <= '0;
      game_reset <= 1'b0;
      rounds     <= 8'd0;
`ifdef SCHED_TIMEOUT_EN
      run_cnt    <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      INIT_c     <= 1'b0;
      game_reset <= 1'b0;

      if (GAMEOVER && state != CLEAR) begin
        // Game over beats every other transition, including a same-cycle
        // WINNER/LOSER, so the interrupted round is never counted.
        state      <= CLEAR;
        gnt        <= 2'b00;
        control    <= 2'b00;
        game_reset <= 1'b1;
        last_owner <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (req != 2'b00) begin
              state <= GRANT;
              owner <= pick;
              gnt   <= pick ? 2'b10 : 2'b01;
              if (pick_load) begin
                INIT_c <= 1'b1;
                INIT_l <= pick_init;
              end
            end
          end
          GRANT: begin
            state   <= RUN;
            control <= owner_ctrl;
`ifdef SCHED_TIMEOUT_EN
            run_cnt <= '0;
`endif
          end
          RUN: begin
            // The owner's req is ignored here: only a round result (or the
            // timeout) hands the counter back.
            if (WINNER || LOSER || run_expired) begin
              state      <= RELEASE;
              gnt        <= 2'b00;
              control    <= 2'b00;
              rounds     <= rounds + 8'd1;
              last_owner <= owner;
            end else begin
              control <= owner_ctrl;
`ifdef SCHED_TIMEOUT_EN
              run_cnt <= run_cnt + CNT_W'(1);
`endif
            end
          end
          RELEASE: begin
            state <= IDLE;
          end
          CLEAR: begin
            state      <= IDLE;
            last_owner <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_sched.sv
`timescale 1ns/1ps
module tb_game_sched;

  localparam int SIZE      = 4;
  localparam int ROUND_MAX = 16;

  localparam int END_WIN   = 0;
  localparam int END_LOSE  = 1;
  localparam int END_GO    = 2;
  localparam int END_WINGO = 3;
  localparam int END_RST   = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      req;
  logic [1:0]      p0_ctrl, p1_ctrl;
  logic            p0_load, p1_load;
  logic [SIZE-1:0] p0_init, p1_init;
  logic            WINNER, LOSER, GAMEOVER;
  logic [1:0]      gnt;
  logic [1:0]      control;
  logic            INIT_c;
  logic [SIZE-1:0] INIT_l;
  logic            game_reset;
  logic [7:0]      rounds;

  game_sched #(.SIZE(SIZE), .ROUND_MAX(ROUND_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .p0_ctrl(p0_ctrl), .p1_ctrl(p1_ctrl),
    .p0_load(p0_load), .p1_load(p1_load),
    .p0_init(p0_init), .p1_init(p1_init),
    .WINNER(WINNER), .LOSER(LOSER), .GAMEOVER(GAMEOVER),
    .gnt(gnt), .control(control), .INIT_c(INIT_c), .INIT_l(INIT_l),
    .game_reset(game_reset), .rounds(rounds)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: who owned the last completed round, how many rounds
  // have completed, and the value INIT_l should be holding.
  int m_last;
  int m_rounds;
  int m_init_l;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then stable and inputs may be changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_owner(input logic [1:0] rq);
    if (rq == 2'b01) return 0;
    if (rq == 2'b10) return 1;
    return (m_last == 1) ? 0 : 1;
  endfunction

  // One complete round from IDLE back to IDLE. run_len = number of RUN cycles.
  task automatic do_round(input logic [1:0] rq, input logic [1:0] ld,
                          input logic [SIZE-1:0] i0, input logic [SIZE-1:0] i1,
                          input int run_len, input int end_kind);
    int          own;
    logic        exp_load;
    logic [1:0]  exp_ctrl;
    logic [1:0]  exp_gnt;
    req = rq; p0_load = ld[0]; p1_load = ld[1]; p0_init = i0; p1_init = i1;
    own      = pick_owner(rq);
    exp_gnt  = (own == 1) ? 2'b10 : 2'b01;
    exp_load = (own == 1) ? ld[1] : ld[0];
    step();
    check_val("gnt_grant", gnt, exp_gnt);
    check_val("init_c_grant", INIT_c, exp_load);
    if (exp_load) m_init_l = (own == 1) ? i1 : i0;
    check_val("init_l_grant", INIT_l, m_init_l);
    for (int c = 0; c < run_len; c++) begin
      // The owner's own req may come and go during the round.
      req     = 2'($urandom);
      p0_ctrl = 2'($urandom);
      p1_ctrl = 2'($urandom);
      p0_load = 1'($urandom);
      p1_load = 1'($urandom);
      exp_ctrl = (own == 1) ? p1_ctrl : p0_ctrl;
      step();
      check_val("gnt_run", gnt, exp_gnt);
      check_val("control_run", control, exp_ctrl);
      check_val("init_c_run", INIT_c, 0);
      check_val("init_l_run", INIT_l, m_init_l);
    end
    req = 2'b00;
    case (end_kind)
      END_WIN, END_LOSE: begin
        if (end_kind == END_WIN) WINNER = 1'b1; else LOSER = 1'b1;
        step();
        WINNER = 1'b0; LOSER = 1'b0;
        m_rounds = (m_rounds + 1) % 256;
        m_last   = own;
        check_val("gnt_release", gnt, 0);
        check_val("control_release", control, 0);
        check_val("rounds_release", rounds, m_rounds);
        check_val("game_reset_release", game_reset, 0);
        step();
        check_val("gnt_idle", gnt, 0);
        check_val("rounds_idle", rounds, m_rounds);
      end
      END_GO, END_WINGO: begin
        GAMEOVER = 1'b1;
        if (end_kind == END_WINGO) WINNER = 1'b1;
        step();
        GAMEOVER = 1'b0; WINNER = 1'b0;
        m_last = 1;
        check_val("game_reset_clear", game_reset, 1);
        check_val("gnt_clear", gnt, 0);
        check_val("rounds_clear", rounds, m_rounds);
        step();
        check_val("game_reset_after", game_reset, 0);
        check_val("rounds_after_clear", rounds, m_rounds);
      end
      default: begin
        reset_n = 1'b0;
        #1;
        m_rounds = 0; m_last = 1; m_init_l = 0;
        check_val("gnt_async_rst", gnt, 0);
        check_val("rounds_async_rst", rounds, 0);
        check_val("control_async_rst", control, 0);
        check_val("init_l_async_rst", INIT_l, 0);
        #1;
        reset_n = 1'b1;
      end
    endcase
    $display("[TB] round req=%b owner=%0d run=%0d end=%0d rounds=%0d", rq, own, run_len, end_kind, rounds);
  endtask

  // Round with no result from the datapath: with the timeout the grant must
  // drop after exactly ROUND_MAX RUN cycles, without it the grant persists.
  task automatic timeout_round();
    int n;
    req = 2'b01; p0_load = 1'b0; p1_load = 1'b0;
    step();
    check_val("gnt_tmo_grant", gnt, 2'b01);
    req = 2'b00;
    step();
    n = 1;
`ifdef SCHED_TIMEOUT_EN
    while (n < 40) begin
      step();
      if (gnt == 2'b00) break;
      n++;
    end
    m_rounds = (m_rounds + 1) % 256;
    m_last = 0;
    check_val("tmo_run_cycles", n, ROUND_MAX);
    check_val("rounds_tmo", rounds, m_rounds);
    step();
`else
    while (n < 100) begin
      step();
      n++;
    end
    check_val("gnt_hold_100", gnt, 2'b01);
    LOSER = 1'b1;
    step();
    LOSER = 1'b0;
    m_rounds = (m_rounds + 1) % 256;
    m_last = 0;
    check_val("gnt_after_hold", gnt, 0);
    check_val("rounds_after_hold", rounds, m_rounds);
    step();
`endif
    $display("[TB] timeout round run_cycles=%0d rounds=%0d", n, rounds);
  endtask

  initial begin
    reset_n = 1'b0;
    req = 2'b00; p0_ctrl = 2'b00; p1_ctrl = 2'b00;
    p0_load = 1'b0; p1_load = 1'b0; p0_init = '0; p1_init = '0;
    WINNER = 1'b0; LOSER = 1'b0; GAMEOVER = 1'b0;
    m_last = 1; m_rounds = 0; m_init_l = 0;
    #3;
    check_val("rst_gnt", gnt, 0);
    check_val("rst_control", control, 0);
    check_val("rst_init_c", INIT_c, 0);
    check_val("rst_init_l", INIT_l, 0);
    check_val("rst_game_reset", game_reset, 0);
    check_val("rst_rounds", rounds, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check_val("idle_gnt", gnt, 0);

    // Lone requester with preload 5, ended by WINNER.
    do_round(2'b01, 2'b01, 4'd5, 4'd0, 3, END_WIN);
    // Reset mid-round.
    do_round(2'b10, 2'b00, 4'd0, 4'd0, 4, END_RST);
    // Contention over three rounds: owners 0, 1, 0.
    do_round(2'b11, 2'b11, 4'd3, 4'd9, 2, END_LOSE);
    do_round(2'b11, 2'b11, 4'd3, 4'd9, 2, END_LOSE);
    do_round(2'b11, 2'b00, 4'd3, 4'd9, 2, END_LOSE);
    check_val("rounds_contention", rounds, 3);
    // Player 1 owns, then WINNER+GAMEOVER collide; next tie goes to player 0.
    do_round(2'b10, 2'b10, 4'd0, 4'd12, 5, END_WINGO);
    do_round(2'b11, 2'b00, 4'd0, 4'd0, 2, END_WIN);
    timeout_round();

    for (int r = 0; r < 40; r++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        check_val("gap_gnt", gnt, 0);
      end
      do_round(2'($urandom_range(1, 3)), 2'($urandom), 4'($urandom), 4'($urandom),
               $urandom_range(1, 12), $urandom_range(0, 9) < 4 ? $urandom_range(0, 1)
                                      : ($urandom_range(0, 9) < 8 ? END_LOSE
                                      : $urandom_range(2, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
